// File: rtl/access_arbiter.sv
// Two-requester access arbiter with code check, lockout and timeout.
// Round-robin grant, registered outputs, synchronous active-low reset.
module access_arbiter #(
  parameter logic [7:0]  PASSWORD    = 8'h05,
  parameter int unsigned MAX_FAIL    = 3,
  parameter int unsigned LOCK_CYCLES = 16,
  parameter int unsigned TIMEOUT     = 32
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [1:0] req,
  input  logic [1:0] confirm,
  input  logic [7:0] user0,
  input  logic [7:0] user1,
  input  logic [1:0] sel,
  output logic [1:0] grant,
  output logic       regP,
  output logic       regQ,
  output logic       auth_fail,
  output logic       locked
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_FAIL,
    S_LOCK
  } state_t;

  localparam logic [7:0] TO_LAST  = 8'(TIMEOUT - 1);
  localparam logic [7:0] LK_LAST  = 8'(LOCK_CYCLES - 1);
  localparam logic [2:0] FAIL_MAX = 3'(MAX_FAIL);

  state_t     state_q, state_d;
  logic       ptr_q, ptr_d;
  logic [7:0] wait_cnt_q, wait_cnt_d;
  logic [7:0] lock_cnt_q, lock_cnt_d;
  logic [2:0] fail_cnt_q, fail_cnt_d;
  logic [1:0] grant_q, grant_d;
  logic       regp_q, regp_d;
  logic       regq_q, regq_d;
  logic       auth_fail_q, auth_fail_d;
  logic       locked_q, locked_d;

  logic       gid;
  logic       g_req;
  logic       g_conf;
  logic       g_sel;
  logic [7:0] g_code;
  logic [2:0] fail_inc;

  assign gid      = grant_q[1];
  assign g_req    = req[gid];
  assign g_conf   = confirm[gid];
  assign g_sel    = sel[gid];
  assign g_code   = gid ? user1 : user0;
  assign fail_inc = (fail_cnt_q == 3'd7) ? 3'd7 : fail_cnt_q + 3'd1;

  // Next-state, counters, pointer and next output values.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    wait_cnt_d = wait_cnt_q;
    lock_cnt_d = lock_cnt_q;
    fail_cnt_d = fail_cnt_q;
    grant_d    = grant_q;
    unique case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d    = S_WAIT;
          wait_cnt_d = 8'd0;
          if (req == 2'b11) begin
            grant_d = ptr_q ? 2'b10 : 2'b01;
          end else begin
            grant_d = req;
          end
        end
      end
      S_WAIT: begin
        if (!g_req) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = ~gid;
        end else if (g_conf) begin
          if (g_code == PASSWORD) begin
            state_d    = S_ACCESS;
            fail_cnt_d = 3'd0;
          end else begin
            state_d = S_FAIL;
          end
        end else if (wait_cnt_q == TO_LAST) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = ~gid;
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end
      S_ACCESS: begin
        if (!g_req) begin
          state_d = S_IDLE;
          grant_d = 2'b00;
          ptr_d   = ~gid;
        end
      end
      S_FAIL: begin
        fail_cnt_d = fail_inc;
        grant_d    = 2'b00;
        ptr_d      = ~gid;
        lock_cnt_d = 8'd0;
        state_d    = (fail_inc == FAIL_MAX) ? S_LOCK : S_IDLE;
      end
      S_LOCK: begin
        if (lock_cnt_q == LK_LAST) begin
          state_d    = S_IDLE;
          fail_cnt_d = 3'd0;
        end else begin
          lock_cnt_d = lock_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        grant_d = 2'b00;
      end
    endcase
    regp_d      = (state_d == S_ACCESS) &  g_sel;
    regq_d      = (state_d == S_ACCESS) & ~g_sel;
    auth_fail_d = (state_d == S_FAIL);
    locked_d    = (state_d == S_LOCK);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      ptr_q       <= 1'b0;
      wait_cnt_q  <= 8'd0;
      lock_cnt_q  <= 8'd0;
      fail_cnt_q  <= 3'd0;
      grant_q     <= 2'b00;
      regp_q      <= 1'b0;
      regq_q      <= 1'b0;
      auth_fail_q <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      wait_cnt_q  <= wait_cnt_d;
      lock_cnt_q  <= lock_cnt_d;
      fail_cnt_q  <= fail_cnt_d;
      grant_q     <= grant_d;
      regp_q      <= regp_d;
      regq_q      <= regq_d;
      auth_fail_q <= auth_fail_d;
      locked_q    <= locked_d;
    end
  end

  assign grant     = grant_q;
  assign regP      = regp_q;
  assign regQ      = regq_q;
  assign auth_fail = auth_fail_q;
  assign locked    = locked_q;

endmodule

// File: tb/tb_access_arbiter.sv
// Bench for access_arbiter: scripted sessions plus random traffic,
// every cycle compared against a session-level reference model.
module tb_access_arbiter;

  localparam logic [7:0] PW    = 8'h05;
  localparam int         MAXF  = 3;
  localparam int         LOCKN = 16;
  localparam int         TO    = 32;

  localparam int M_IDLE   = 0;
  localparam int M_WAIT   = 1;
  localparam int M_ACCESS = 2;
  localparam int M_FAIL   = 3;
  localparam int M_LOCK   = 4;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [1:0] req;
  logic [1:0] confirm;
  logic [7:0] user0;
  logic [7:0] user1;
  logic [1:0] sel;
  logic [1:0] grant;
  logic       regP;
  logic       regQ;
  logic       auth_fail;
  logic       locked;

  int n_vec = 0;
  int n_err = 0;

  int m_mode  = M_IDLE;
  int m_owner = -1;
  int m_ptr   = 0;
  int m_fails = 0;
  int m_wleft = 0;
  int m_lleft = 0;
  bit m_p     = 1'b0;

  always #5 clock = ~clock;

  access_arbiter #(
    .PASSWORD   (PW),
    .MAX_FAIL   (MAXF),
    .LOCK_CYCLES(LOCKN),
    .TIMEOUT    (TO)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .req      (req),
    .confirm  (confirm),
    .user0    (user0),
    .user1    (user1),
    .sel      (sel),
    .grant    (grant),
    .regP     (regP),
    .regQ     (regQ),
    .auth_fail(auth_fail),
    .locked   (locked)
  );

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic give_up();
    m_ptr   = 1 - m_owner;
    m_owner = -1;
    m_mode  = M_IDLE;
  endtask

  // Reference: one clock edge of the session rules.
  task automatic model_step();
    logic [7:0] code;
    if (!reset_n) begin
      m_mode  = M_IDLE;
      m_owner = -1;
      m_ptr   = 0;
      m_fails = 0;
      m_p     = 1'b0;
      return;
    end
    case (m_mode)
      M_IDLE: begin
        if (req != 2'b00) begin
          if (req == 2'b11) m_owner = m_ptr;
          else m_owner = req[1] ? 1 : 0;
          m_mode  = M_WAIT;
          m_wleft = TO;
        end
      end
      M_WAIT: begin
        m_wleft--;
        code = (m_owner == 1) ? user1 : user0;
        if (!req[m_owner]) begin
          give_up();
        end else if (confirm[m_owner]) begin
          if (code == PW) begin
            m_mode  = M_ACCESS;
            m_fails = 0;
            m_p     = sel[m_owner];
          end else begin
            m_mode = M_FAIL;
          end
        end else if (m_wleft == 0) begin
          give_up();
        end
      end
      M_ACCESS: begin
        if (!req[m_owner]) give_up();
        else m_p = sel[m_owner];
      end
      M_FAIL: begin
        if (m_fails < 7) m_fails++;
        give_up();
        if (m_fails == MAXF) begin
          m_mode  = M_LOCK;
          m_lleft = LOCKN;
        end
      end
      default: begin
        m_lleft--;
        if (m_lleft == 0) begin
          m_fails = 0;
          m_mode  = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic tick();
    logic [1:0] eg;
    @(posedge clock);
    model_step();
    #1;
    if (m_owner < 0) eg = 2'b00;
    else eg = (m_owner == 0) ? 2'b01 : 2'b10;
    chk("grant", {6'd0, grant}, {6'd0, eg});
    chk("regP", {7'd0, regP}, {7'd0, (m_mode == M_ACCESS) && m_p});
    chk("regQ", {7'd0, regQ}, {7'd0, (m_mode == M_ACCESS) && !m_p});
    chk("auth_fail", {7'd0, auth_fail}, {7'd0, m_mode == M_FAIL});
    chk("locked", {7'd0, locked}, {7'd0, m_mode == M_LOCK});
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0;
    req     = 2'b00;
    confirm = 2'b00;
    sel     = 2'b00;
    user0   = 8'h00;
    user1   = 8'h00;
    tick();
    tick();
    reset_n = 1'b1;

    // Single requester, good code, register P.
    req = 2'b01;
    tick();
    user0   = PW;
    confirm = 2'b01;
    sel     = 2'b01;
    tick();
    confirm = 2'b00;
    repeat (3) tick();
    req = 2'b00;
    repeat (2) tick();

    // Both requesting from reset, then hand-over.
    do_reset();
    req = 2'b11;
    tick();
    confirm = 2'b01;
    tick();
    confirm = 2'b00;
    tick();
    req = 2'b10;
    repeat (3) tick();
    req = 2'b00;
    tick();

    // Reset during ACCESS with register Q selected.
    do_reset();
    req = 2'b01;
    tick();
    user0   = PW;
    confirm = 2'b01;
    sel     = 2'b00;
    tick();
    confirm = 2'b00;
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    req     = 2'b00;
    tick();

    // Timeouts with both requesting, pointer alternates.
    req = 2'b11;
    repeat (100) tick();
    req = 2'b00;
    tick();

    // Repeated wrong codes into lockout and beyond.
    do_reset();
    user0   = 8'hAA;
    req     = 2'b01;
    confirm = 2'b01;
    repeat (40) tick();
    req     = 2'b00;
    confirm = 2'b00;
    repeat (20) tick();

    // Two failures, then a good code, then one failure.
    do_reset();
    user0   = 8'hAA;
    req     = 2'b01;
    confirm = 2'b01;
    for (int i = 0; i < 20 && m_fails < 2; i++) tick();
    user0 = PW;
    repeat (4) tick();
    req = 2'b00;
    tick();
    user0 = 8'hAA;
    req   = 2'b01;
    repeat (4) tick();
    req     = 2'b00;
    confirm = 2'b00;
    repeat (3) tick();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 7) == 0) req[0] = ~req[0];
      if ($urandom_range(0, 7) == 0) req[1] = ~req[1];
      confirm[0] = ($urandom_range(0, 3) == 0);
      confirm[1] = ($urandom_range(0, 3) == 0);
      user0   = $urandom_range(0, 1) ? PW : 8'($urandom);
      user1   = $urandom_range(0, 1) ? PW : 8'($urandom);
      sel     = 2'($urandom);
      reset_n = ($urandom_range(0, 60) != 0);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
